// File: rtl/uart_rx.sv
// 8-N-1 UART receiver with 2-flop input synchroniser, mid-bit sampling and one-cycle strobes.
// Optional parity stage (8-E-1 / 8-O-1) enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 87
`ifdef UART_RX_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_parity_err,
    output logic       rx_busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [1:0]    r_sync;
    logic          w_rx_s;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic [2:0]    r_idx;
    logic [2:0]    w_idx_nx;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nx;
    logic [7:0]    r_data;
    logic [7:0]    w_data_nx;
    logic          r_valid;
    logic          w_valid_nx;
    logic          r_ferr;
    logic          w_ferr_nx;
    logic          r_busy;
    logic          w_busy_nx;
`ifdef UART_RX_PARITY_EN
    logic          r_par_bad;
    logic          w_par_bad_nx;
    logic          r_perr;
    logic          w_perr_nx;
`endif

    assign w_rx_s = r_sync[1];

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync    <= 2'b11;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_sync    <= {r_sync[0], rx_serial};
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_idx     <= w_idx_nx;
            r_shift   <= w_shift_nx;
            r_data    <= w_data_nx;
            r_valid   <= w_valid_nx;
            r_ferr    <= w_ferr_nx;
            r_busy    <= w_busy_nx;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= w_par_bad_nx;
            r_perr    <= w_perr_nx;
`endif
        end
    end

    // Next-state and output decode; the counter clears on every state change
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt + CW'(1);
        w_idx_nx     = r_idx;
        w_shift_nx   = r_shift;
        w_data_nx    = r_data;
        w_valid_nx   = 1'b0;
        w_ferr_nx    = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nx = r_par_bad;
        w_perr_nx    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                if (!w_rx_s) w_state_nx = S_START;
            end
            S_START: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_nx = '0;
                    if (w_rx_s) begin
                        w_state_nx = S_IDLE;
                    end else begin
                        w_state_nx = S_DATA;
                        w_idx_nx   = '0;
                    end
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nx          = '0;
                    w_shift_nx[r_idx] = w_rx_s;
                    if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nx = S_PARITY;
`else
                        w_state_nx = S_STOP;
`endif
                    end else begin
                        w_idx_nx = r_idx + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nx     = '0;
                    w_par_bad_nx = w_rx_s ^ (^r_shift) ^ PARITY_ODD;
                    w_state_nx   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nx = '0;
                    if (w_rx_s) begin
                        w_data_nx  = r_shift;
                        w_valid_nx = 1'b1;
`ifdef UART_RX_PARITY_EN
                        w_perr_nx  = r_par_bad;
`endif
                        w_state_nx = S_IDLE;
                    end else begin
                        w_ferr_nx  = 1'b1;
                        w_state_nx = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                w_cnt_nx = '0;
                if (w_rx_s) w_state_nx = S_IDLE;
            end
            default: begin
                w_cnt_nx   = '0;
                w_state_nx = S_IDLE;
            end
        endcase
        w_busy_nx = (w_state_nx != S_IDLE);
    end

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_frame_err = r_ferr;
    assign rx_busy      = r_busy;
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = r_perr;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed corner cases plus randomized frames
// checked against a frame-level event model.
module tb_uart_rx;

    localparam int unsigned CPB     = 8;
    localparam int          LATENCY = CPB * 9 + (CPB - 1) / 2 + 4;
    localparam bit          PAR_ODD = 1'b0;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       rx_serial = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_parity_err;
    logic       rx_busy;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    typedef struct packed {
        logic [1:0]  kind;   // 1 = valid, 2 = frame error
        logic [7:0]  data;
        logic        perr;
        logic [31:0] cyc;
    } ev_t;

    ev_t q_exp[$];
    ev_t q_obs[$];
    logic [7:0] last_good = 8'h00;
    logic       tb_par = 1'b0;

    uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) u_dut (
        .clk          (clk),
        .nrst         (nrst),
        .rx_serial    (rx_serial),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_parity_err(rx_parity_err),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Strobe monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rx_valid || rx_frame_err) begin
            check("excl", {31'b0, rx_valid & rx_frame_err}, 32'd0);
            q_obs.push_back('{kind: (rx_valid ? 2'd1 : 2'd2), data: rx_data,
                              perr: rx_parity_err, cyc: cyc});
        end
    end

    task automatic hold_bits(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b);
        rx_serial = 1'b0;
        hold_bits(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            hold_bits(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx_serial = tb_par;
        hold_bits(CPB);
`endif
        rx_serial = stop_b;
        hold_bits(CPB);
    endtask

    function automatic logic exp_perr(input logic [7:0] b);
`ifdef UART_RX_PARITY_EN
        return ((^b) ^ tb_par ^ PAR_ODD);
`else
        return 1'b0 & b[0];
`endif
    endfunction

    task automatic expect_good(input logic [7:0] b);
        q_exp.push_back('{kind: 2'd1, data: b, perr: exp_perr(b), cyc: 32'd0});
        last_good = b;
    endtask

    task automatic expect_ferr();
        q_exp.push_back('{kind: 2'd2, data: last_good, perr: 1'b0, cyc: 32'd0});
    endtask

    task automatic compare_events(input string tag);
        check({tag, ":count"}, q_obs.size(), q_exp.size());
        for (int i = 0; i < q_exp.size() && i < q_obs.size(); i++) begin
            check({tag, ":kind"}, {30'b0, q_obs[i].kind}, {30'b0, q_exp[i].kind});
            check({tag, ":data"}, {24'b0, q_obs[i].data}, {24'b0, q_exp[i].data});
            check({tag, ":perr"}, {31'b0, q_obs[i].perr}, {31'b0, q_exp[i].perr});
        end
        q_exp.delete();
        q_obs.delete();
    endtask

    initial begin
        logic [7:0] b;
        logic       bad;
        int         t0;
        logic [7:0] pat;

        // Power-on reset values
        hold_bits(3);
        check("rst:data", {24'b0, rx_data}, 32'h0);
        check("rst:valid", {31'b0, rx_valid}, 32'h0);
        check("rst:ferr", {31'b0, rx_frame_err}, 32'h0);
        check("rst:perr", {31'b0, rx_parity_err}, 32'h0);
        check("rst:busy", {31'b0, rx_busy}, 32'h0);
        nrst = 1'b1;
        hold_bits(2 * CPB);

        // Reset in the middle of a 0x3C frame
        pat = 8'h3C;
        rx_serial = 1'b0;
        hold_bits(CPB);
        for (int i = 0; i < 4; i++) begin
            rx_serial = pat[i];
            hold_bits(CPB);
        end
        check("t1:busy_before", {31'b0, rx_busy}, 32'h1);
        nrst = 1'b0;
        #1;
        check("t1:busy", {31'b0, rx_busy}, 32'h0);
        check("t1:data", {24'b0, rx_data}, 32'h0);
        check("t1:valid", {31'b0, rx_valid}, 32'h0);
        check("t1:ferr", {31'b0, rx_frame_err}, 32'h0);
        rx_serial = 1'b1;
        @(negedge clk);
        nrst = 1'b1;
        hold_bits(20 * CPB);
        compare_events("t1");

        // Single 0x55 frame with latency measurement
        tb_par = 1'b0;
        t0 = cyc;
        send_frame(8'h55, 1'b1);
        expect_good(8'h55);
        hold_bits(CPB);
        check("t2:busy_after", {31'b0, rx_busy}, 32'h0);
        if (q_obs.size() > 0)
            check("t2:latency", q_obs[0].cyc - t0, LATENCY);
        compare_events("t2");

        // Two-clock glitch is rejected
        rx_serial = 1'b0;
        hold_bits(2);
        rx_serial = 1'b1;
        hold_bits(CPB);
        check("t3:busy", {31'b0, rx_busy}, 32'h0);
        hold_bits(2 * CPB);
        compare_events("t3");

        // Bad stop bit followed by a held-low line
        send_frame(8'hA3, 1'b0);
        expect_ferr();
        hold_bits(3 * CPB);
        check("t4:busy_break", {31'b0, rx_busy}, 32'h1);
        check("t4:data_kept", {24'b0, rx_data}, 32'h55);
        rx_serial = 1'b1;
        hold_bits(2 * CPB);
        check("t4:busy_idle", {31'b0, rx_busy}, 32'h0);
        compare_events("t4");

        // Back-to-back frames with no idle gap
        send_frame(8'h00, 1'b1);
        expect_good(8'h00);
        tb_par = 1'b1;
        send_frame(8'hFF, 1'b1);
        tb_par = 1'b0;
        expect_good(8'hFF);
        hold_bits(2 * CPB);
        compare_events("t5");

`ifdef UART_RX_PARITY_EN
        // Parity correct then parity wrong on 0x07
        tb_par = 1'b1;
        send_frame(8'h07, 1'b1);
        expect_good(8'h07);
        tb_par = 1'b0;
        send_frame(8'h07, 1'b1);
        expect_good(8'h07);
        hold_bits(2 * CPB);
        compare_events("t6");
`endif

        // Randomized frames with random gaps and occasional bad stop bits
        for (int f = 0; f < 40; f++) begin
            b      = 8'($urandom);
            bad    = ($urandom_range(0, 7) == 0);
            tb_par = 1'($urandom);
            send_frame(b, ~bad);
            if (bad) begin
                expect_ferr();
                hold_bits($urandom_range(0, 3 * CPB));
                rx_serial = 1'b1;
                hold_bits(CPB);
            end else begin
                expect_good(b);
            end
            hold_bits($urandom_range(0, 2 * CPB));
        end
        hold_bits(12 * CPB);
        check("rnd:busy_end", {31'b0, rx_busy}, 32'h0);
        compare_events("rnd");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
